lfsr_prng: RTL and testbench
============================

// Module: lfsr_prng
//
// PURPOSE
//   Parametrised Fibonacci LFSR pseudo-random source with a ready/valid output handshake.
//   Supports a runtime seed load, all-zero lock-up protection and automatic period detection.
//   Generalised successor to the fixed 8-bit free-running LFSR.
//   Feeds test-pattern and stimulus consumers that can apply back-pressure.
//
// PARAMETERS
//   WIDTH  8      state/output width in bits, legal range 3..32
//   TAPS   8'hB8  feedback mask (WIDTH bits); bit i set => state[i] feeds XOR. Default is x^8+x^6+x^5+x^4+1
//   SEED   1      reset seed and zero-seed substitute; must be non-zero
//
// PORTS
//   clk         in   1      clock, rising edge
//   rst         in   1      asynchronous reset, active-low
//   en          in   1      run enable
//   seed_load   in   1      load seed into state (one-cycle strobe)
//   seed        in   WIDTH  seed value sampled when seed_load=1
//   out_ready   in   1      consumer ready
//   out_valid   out  1      out_data holds a valid sample
//   out_data    out  WIDTH  current LFSR state
//   wrap        out  1      one-cycle pulse: a step returned state to the start value
//   period      out  WIDTH  step count of the last completed cycle; 0 = none yet
//   seed_err    out  1      one-cycle pulse: zero seed was loaded and replaced
//
// BEHAVIOUR
//   Reset (rst=0, async) values:
//     - outputs: out_data=SEED, out_valid=0, wrap=0, period=0, seed_err=0
//     - internal: start_reg=SEED, step_cnt=0, FSM=IDLE
//   Step function:
//     - fb = ^(state & TAPS)
//     - next = {state[WIDTH-2:0], fb}
//     - out_data is the state register itself
//   FSM states and transitions:
//     - IDLE: out_valid=0; en=1 -> RUN at the next edge, with out_valid=1 from that edge.
//     - RUN: out_valid=1. A transfer is out_valid & out_ready at a rising edge.
//       On each transfer: state<=next and step_cnt++. New data is visible the cycle after the transfer.
//       out_valid=1 & out_ready=0 -> out_data held stable, no step.
//       en=0 -> IDLE at the next edge. A transfer in that same cycle still steps.
//   Seed load (highest priority, any state):
//     - state<=seed, start_reg<=seed, step_cnt<=0, out_valid<=0 for that edge.
//     - A coincident transfer is discarded: no step.
//     - FSM goes to IDLE, then re-enters RUN next cycle if en=1.
//     - seed==0 -> SEED is loaded instead and seed_err pulses one cycle.
//   Period detection:
//     - Applies when a transfer step yields next==start_reg.
//     - wrap=1 for exactly one cycle, period<=step_cnt+1, step_cnt<=0.
//     - step_cnt is WIDTH+1 bits internally, so it cannot overflow before the wrap (max 2^WIDTH-1).
//     - Non-maximal TAPS report their true cycle length.
//   The state never holds zero; all-zero is unreachable from a non-zero seed.
//   Reset mid-transfer: all registers return to their reset values immediately; no partial step.
//
// TESTING
//   1. Defaults, en=1, out_ready=1 after reset -> out_data 0x01,0x02,0x04,0x08,0x11 on consecutive transfers.
//   2. 255 transfers from seed 0x01 -> wrap pulses once, on the 255th; period=255; out_data=0x01 again.
//   3. out_ready toggled 1,0,0,1 -> out_data stable while ready=0; exactly two steps total; no value skipped.
//   4. seed_load seed=0x5A with coincident transfer -> out_valid=0 one cycle; next valid out_data=0x5A; step_cnt=0.
//   5. seed_load seed=0x00 -> seed_err one-cycle pulse; out_data=0x01; sequence as scenario 1.
//   6. rst low mid-run, then en dropped -> out_valid=0 async and out_data=0x01, period=0; en=0 stays IDLE.

Source files
------------

// File: rtl/lfsr_prng.sv
// Fibonacci LFSR pseudo-random source with ready/valid output, runtime seed load,
// zero-seed substitution and automatic cycle-length (period) detection.
module lfsr_prng #(
  parameter int unsigned           WIDTH = 8,
  parameter logic [WIDTH-1:0]      TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0]      SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             wrap_o,
  output logic [WIDTH-1:0] period_o,
  output logic             seed_err_o
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH:0]   cnt_q, cnt_d;
  logic [WIDTH:0]   cnt_inc;
  logic             wrap_q, wrap_d;
  logic             seed_err_q, seed_err_d;
  logic             fb;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] load_val;
  logic             xfer;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q      <= IDLE;
      lfsr_q     <= SEED;
      start_q    <= SEED;
      period_q   <= '0;
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
      seed_err_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      lfsr_q     <= lfsr_d;
      start_q    <= start_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_d;
      seed_err_q <= seed_err_d;
    end
  end

  always_comb begin
    fb         = ^(lfsr_q & TAPS);
    step_next  = {lfsr_q[WIDTH-2:0], fb};
    load_val   = (seed_i == '0) ? SEED : seed_i;
    xfer       = (fsm_q == RUN) && out_ready_i;
    cnt_inc    = cnt_q + 1'b1;

    fsm_d      = fsm_q;
    lfsr_d     = lfsr_q;
    start_d    = start_q;
    period_d   = period_q;
    cnt_d      = cnt_q;
    wrap_d     = 1'b0;
    seed_err_d = 1'b0;

    case (fsm_q)
      IDLE: if (en_i)  fsm_d = RUN;
      RUN:  if (!en_i) fsm_d = IDLE;
      default:         fsm_d = IDLE;
    endcase

    // Seed load wins over everything, including a transfer on the same edge.
    if (seed_load_i) begin
      lfsr_d     = load_val;
      start_d    = load_val;
      cnt_d      = '0;
      fsm_d      = IDLE;
      seed_err_d = (seed_i == '0);
    end else if (xfer) begin
      lfsr_d = step_next;
      if (step_next == start_q) begin
        wrap_d   = 1'b1;
        period_d = cnt_inc[WIDTH-1:0];
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  assign out_valid_o = (fsm_q == RUN);
  assign out_data_o  = lfsr_q;
  assign wrap_o      = wrap_q;
  assign period_o    = period_q;
  assign seed_err_o  = seed_err_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Bench for lfsr_prng: directed scenarios plus randomized handshake/seed traffic
// checked against an arithmetic reference model of the LFSR sequence.
module tb_lfsr_prng;
  localparam int W      = 8;
  localparam int TAPS_I = 'hB8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         seed_load;
  logic [W-1:0] seed;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         wrap;
  logic [W-1:0] period;
  logic         seed_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int m_state, m_start, m_cnt, m_period;
  bit m_run, m_wrap, m_err;

  lfsr_prng #(.WIDTH(W), .TAPS(8'hB8), .SEED(8'h01)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .seed_load_i(seed_load), .seed_i(seed),
    .out_ready_i(out_ready), .out_valid_o(out_valid), .out_data_o(out_data),
    .wrap_o(wrap), .period_o(period), .seed_err_o(seed_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Next value: shift left by one (doubling mod 2^W) and add the parity of the tapped bits.
  function automatic int ref_next(int s);
    int ones = 0;
    for (int i = 0; i < W; i++)
      if (((s >> i) % 2 == 1) && ((TAPS_I >> i) % 2 == 1)) ones++;
    return (s * 2) % (1 << W) + ones % 2;
  endfunction

  task automatic model_reset();
    m_state = 1; m_start = 1; m_cnt = 0; m_period = 0;
    m_run = 0; m_wrap = 0; m_err = 0;
  endtask

  // Apply the current inputs to the model, then let the DUT take the same edge.
  task automatic tick();
    bit xfer;
    int v, n;
    xfer   = m_run && out_ready;
    m_wrap = 0;
    m_err  = 0;
    if (seed_load) begin
      v       = (seed == 0) ? 1 : int'(seed);
      m_state = v;
      m_start = v;
      m_cnt   = 0;
      m_run   = 0;
      m_err   = (seed == 0);
    end else begin
      if (xfer) begin
        n = ref_next(m_state);
        m_cnt++;
        if (n == m_start) begin
          m_wrap   = 1;
          m_period = m_cnt;
          m_cnt    = 0;
        end
        m_state = n;
      end
      m_run = en;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", out_valid); else pass_cnt++;
    total_cnt++;
    if (out_data !== 8'h01) $display("FAIL reset_data: got %02h want 01", out_data); else pass_cnt++;
    total_cnt++;
    if (period !== 8'h00) $display("FAIL reset_period: got %0d want 0", period); else pass_cnt++;
    total_cnt++;
    if (wrap !== 1'b0) $display("FAIL reset_wrap: got %0b want 0", wrap); else pass_cnt++;
    total_cnt++;
    if (seed_err !== 1'b0) $display("FAIL reset_seed_err: got %0b want 0", seed_err); else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_sequence();
    logic [W-1:0] exp_seq [4];
    exp_seq = '{8'h02, 8'h04, 8'h08, 8'h11};
    en = 1'b1; out_ready = 1'b1;
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 8'h01)
      $display("FAIL seq_start: got valid=%0b data=%02h want valid=1 data=01", out_valid, out_data);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      tick();
      total_cnt++;
      if (out_data !== exp_seq[k])
        $display("FAIL seq_step%0d: got %02h want %02h", k + 1, out_data, exp_seq[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_period();
    int wraps = 0;
    for (int t = 5; t <= 255; t++) begin
      tick();
      if (wrap === 1'b1) wraps++;
      total_cnt++;
      if (wrap !== (t == 255))
        $display("FAIL period_wrap_at_%0d: got %0b want %0b", t, wrap, (t == 255));
      else pass_cnt++;
    end
    total_cnt++;
    if (wraps != 1) $display("FAIL period_wrap_count: got %0d want 1", wraps); else pass_cnt++;
    total_cnt++;
    if (period !== 8'd255) $display("FAIL period_value: got %0d want 255", period); else pass_cnt++;
    total_cnt++;
    if (out_data !== 8'h01) $display("FAIL period_data: got %02h want 01", out_data); else pass_cnt++;
    tick();
    total_cnt++;
    if (wrap !== 1'b0) $display("FAIL period_wrap_pulse: got %0b want 0", wrap); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d0, d1, d2;
    d0 = 8'(m_state);
    d1 = 8'(ref_next(d0));
    d2 = 8'(ref_next(d1));
    out_ready = 1'b1; tick();
    total_cnt++;
    if (out_data !== d1) $display("FAIL bp_first_step: got %02h want %02h", out_data, d1); else pass_cnt++;
    out_ready = 1'b0; tick();
    total_cnt++;
    if (out_data !== d1) $display("FAIL bp_hold1: got %02h want %02h", out_data, d1); else pass_cnt++;
    tick();
    total_cnt++;
    if (out_data !== d1 || out_valid !== 1'b1)
      $display("FAIL bp_hold2: got data=%02h valid=%0b want data=%02h valid=1", out_data, out_valid, d1);
    else pass_cnt++;
    out_ready = 1'b1; tick();
    total_cnt++;
    if (out_data !== d2) $display("FAIL bp_second_step: got %02h want %02h", out_data, d2); else pass_cnt++;
    for (int i = 0; i < 40; i++) begin
      out_ready = $urandom % 2;
      tick();
      total_cnt++;
      if (out_data !== 8'(m_state))
        $display("FAIL bp_random%0d: got %02h want %02h", i, out_data, 8'(m_state));
      else pass_cnt++;
    end
  endtask

  task automatic test_seed_load();
    int steps = 0;
    bit seen = 0;
    out_ready = 1'b1; en = 1'b1;
    seed = 8'h5A; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || out_data !== 8'h5A || seed_err !== 1'b0)
      $display("FAIL seed_load_edge: got valid=%0b data=%02h err=%0b want valid=0 data=5a err=0",
               out_valid, out_data, seed_err);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A)
      $display("FAIL seed_load_first: got valid=%0b data=%02h want valid=1 data=5a", out_valid, out_data);
    else pass_cnt++;
    // A cleared step counter shows up as a full 255-step period measured from the new seed.
    while (!seen && steps < 300) begin
      tick();
      steps++;
      if (wrap === 1'b1) seen = 1;
    end
    total_cnt++;
    if (!seen || steps != 255)
      $display("FAIL seed_load_period: got wrap_seen=%0b after %0d steps want 255", seen, steps);
    else pass_cnt++;
    total_cnt++;
    if (period !== 8'd255 || out_data !== 8'h5A)
      $display("FAIL seed_load_wrap_state: got period=%0d data=%02h want 255 5a", period, out_data);
    else pass_cnt++;
  endtask

  task automatic test_zero_seed();
    logic [W-1:0] exp_seq [4];
    exp_seq = '{8'h02, 8'h04, 8'h08, 8'h11};
    seed = 8'h00; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    total_cnt++;
    if (seed_err !== 1'b1 || out_data !== 8'h01 || out_valid !== 1'b0)
      $display("FAIL zero_seed_load: got err=%0b data=%02h valid=%0b want 1 01 0", seed_err, out_data, out_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (seed_err !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h01)
      $display("FAIL zero_seed_after: got err=%0b valid=%0b data=%02h want 0 1 01", seed_err, out_valid, out_data);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      tick();
      total_cnt++;
      if (out_data !== exp_seq[k])
        $display("FAIL zero_seed_seq%0d: got %02h want %02h", k + 1, out_data, exp_seq[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midrun();
    en = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    total_cnt++;
    if (out_valid !== 1'b0 || out_data !== 8'h01 || period !== 8'h00 || wrap !== 1'b0)
      $display("FAIL midrun_reset: got valid=%0b data=%02h period=%0d wrap=%0b want 0 01 0 0",
               out_valid, out_data, period, wrap);
    else pass_cnt++;
    en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if (out_valid !== 1'b0 || out_data !== 8'h01)
        $display("FAIL midrun_idle%0d: got valid=%0b data=%02h want 0 01", i, out_valid, out_data);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      out_ready = $urandom % 2;
      seed_load = ($urandom_range(0, 19) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      tick();
      total_cnt++;
      if (out_valid !== m_run || out_data !== 8'(m_state) || wrap !== m_wrap ||
          period !== 8'(m_period) || seed_err !== m_err)
        $display("FAIL random%0d: got v=%0b d=%02h w=%0b p=%0d e=%0b want v=%0b d=%02h w=%0b p=%0d e=%0b",
                 i, out_valid, out_data, wrap, period, seed_err,
                 m_run, 8'(m_state), m_wrap, m_period, m_err);
      else pass_cnt++;
    end
    seed_load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; seed_load = 1'b0; seed = '0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_sequence();
    test_period();
    test_backpressure();
    test_seed_load();
    test_zero_seed();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
